// File: rtl/if_fetch_queue.sv
// if_fetch_queue: PC owner, instruction fetch and decode FIFO.
// clk/rst_n; im_addr/im_instr memory side;
// redirect_valid/redirect_pc flush+restart;
// id_valid/id_instr/id_pc/id_ready decode side;
// align_err sticky misaligned-target flag.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  output logic        align_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic          full;

  assign im_addr  = pc;
  assign full     = (count == FULL_CNT);
  assign id_valid = (count != '0);
  assign id_instr = q_instr[rptr];
  assign id_pc    = q_pc[rptr];

  // A full queue may still fetch when the head leaves this cycle.
  assign pop  = id_valid & id_ready;
  assign push = ~redirect_valid & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      align_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      // Flush drops the head even if decode took it.
      pc    <= {redirect_pc[31:2], 2'b00};
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      if (redirect_pc[1:0] != 2'b00)
        align_err <= 1'b1;
    end else begin
      if (push) begin
        q_instr[wptr] <= im_instr;
        q_pc[wptr]    <= pc;
        wptr          <= wptr + 1'b1;
        pc            <= pc + 32'd4;
      end
      if (pop)
        rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push)
                     - (AW+1)'(pop);
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed bench for if_fetch_queue.
// Memory word i returns 32'h1000_0000 + i.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;
  logic        align_err;

  int checks = 0;
  int errors = 0;

  if_fetch_queue #(
    .RESET_PC(32'h0000_0000),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .im_addr(im_addr),
    .im_instr(im_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .id_valid(id_valid),
    .id_instr(id_instr),
    .id_pc(id_pc),
    .id_ready(id_ready),
    .align_err(align_err)
  );

  assign im_instr = 32'h1000_0000
                  + {2'b00, im_addr[31:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_seq(input logic rdy);
    rst_n = 1'b0;
    @(negedge clk);
    id_ready = rdy;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    #2;
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc",    id_pc,    32'h0);
    chk("rst_aerr",  32'(align_err), 32'd0);
    chk("rst_addr",  im_addr,  32'h0);

    // Streaming with decode always ready
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("s0_valid", 32'(id_valid), 32'd1);
    chk("s0_pc",    id_pc,    32'h0);
    chk("s0_instr", id_instr, 32'h1000_0000);
    step();
    chk("s1_pc",    id_pc,    32'h4);
    chk("s1_instr", id_instr, 32'h1000_0001);
    step();
    chk("s2_pc",    id_pc,    32'h8);
    chk("s2_instr", id_instr, 32'h1000_0002);

    // Stall: queue fills, pc holds
    reset_seq(1'b0);
    for (int i = 0; i < 10; i++) step();
    chk("full_valid", 32'(id_valid), 32'd1);
    chk("full_pc",    id_pc,   32'h0);
    chk("full_addr",  im_addr, 32'h10);
    id_ready = 1'b1;
    step();
    chk("drain_pc4",  id_pc, 32'h4);
    step();
    chk("drain_pc8",  id_pc, 32'h8);
    step();
    chk("drain_pc12", id_pc, 32'hC);
    step();
    chk("drain_pc16", id_pc, 32'h10);
    chk("drain_in16", id_instr, 32'h1000_0004);
    chk("drain_addr", im_addr, 32'h20);

    // Redirect with three entries queued
    reset_seq(1'b0);
    for (int i = 0; i < 3; i++) step();
    chk("q3_addr", im_addr, 32'hC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    id_ready       = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("rd_valid", 32'(id_valid), 32'd0);
    chk("rd_addr",  im_addr, 32'h40);
    step();
    chk("rd_v2",    32'(id_valid), 32'd1);
    chk("rd_pc",    id_pc,    32'h40);
    chk("rd_instr", id_instr, 32'h1000_0010);

    // Misaligned target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step();
    chk("ma_aerr", 32'(align_err), 32'd1);
    chk("ma_addr", im_addr, 32'h40);
    chk("ma_valid", 32'(id_valid), 32'd0);
    redirect_valid = 1'b0;
    step();
    chk("ma_pc", id_pc, 32'h40);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step();
    redirect_valid = 1'b0;
    chk("ma_sticky", 32'(align_err), 32'd1);
    chk("ma_addr2",  im_addr, 32'h80);

    // Async reset with a full queue
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("f2_valid", 32'(id_valid), 32'd1);
    chk("f2_addr",  im_addr, 32'h90);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(id_valid), 32'd0);
    chk("ar_aerr",  32'(align_err), 32'd0);
    chk("ar_addr",  im_addr, 32'h0);
    @(negedge clk);
    id_ready = 1'b1;
    rst_n = 1'b1;
    step();
    chk("ar_pc",    id_pc,    32'h0);
    chk("ar_instr", id_instr, 32'h1000_0000);

    // PC wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    step();
    chk("w0_pc",    id_pc,    32'hFFFF_FFF8);
    chk("w0_instr", id_instr, 32'h4FFF_FFFE);
    step();
    chk("w1_pc",    id_pc,    32'hFFFF_FFFC);
    step();
    chk("w2_pc",    id_pc,    32'h0);
    chk("w2_instr", id_instr, 32'h1000_0000);
    chk("w2_aerr",  32'(align_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
